// File: rtl/countdown_pkg.sv
// ----------------------------------------------------------------------------
// countdown_pkg : shared types for the countdown controller   (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

package countdown_pkg;

  localparam int CD_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } cd_state_t;

  // RUN and PAUSE are the only states in which the prescaler keeps its phase.
  function automatic logic is_active(input cd_state_t s);
    return (s == RUN) || (s == PAUSE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ----------------------------------------------------------------------------
// tick_prescaler : divides enabled clk cycles into one-cycle count ticks (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module tick_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_phase;

  // With PRESCALE==1, LAST is 0 and the phase never leaves 0.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_phase <= '0;
    end else if (en) begin
      r_phase <= (r_phase == LAST) ? '0 : r_phase + PW'(1);
    end
  end

  assign tick = en && (r_phase == LAST);

endmodule

`default_nettype wire

// File: rtl/countdown_ctrl.sv
// ----------------------------------------------------------------------------
// countdown_ctrl : prescaled down-counter with start/pause/load/auto-reload (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int               WIDTH       = CD_WIDTH,
  parameter int               PRESCALE    = 4,
  parameter logic [WIDTH-1:0] START_VALUE = {WIDTH{1'b1}},
  parameter int               AUTO_RELOAD = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             zero,
  output logic             done
);

  cd_state_t        r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_running;
  logic             r_done;

  logic w_en;
  logic w_clr;
  logic w_tick;

  assign w_en  = (r_state == RUN) && !pause;
  assign w_clr = load || !is_active(r_state);

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (w_en),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_count   <= START_VALUE;
      r_reload  <= START_VALUE;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (load) begin
        r_count   <= load_value;
        r_reload  <= load_value;
        r_state   <= IDLE;
        r_running <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              if (r_count != '0) begin
                r_state   <= RUN;
                r_running <= 1'b1;
              end else begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end
            end
          end

          RUN: begin
            if (pause) begin
              r_state   <= PAUSE;
              r_running <= 1'b0;
            end else if (w_tick) begin
              // Treat 0 like 1 so the count can never wrap below zero.
              if (r_count <= WIDTH'(1)) begin
                r_count   <= '0;
                r_state   <= DONE;
                r_running <= 1'b0;
                r_done    <= 1'b1;
              end else begin
                r_count <= r_count - WIDTH'(1);
              end
            end
          end

          PAUSE: begin
            if (!pause) begin
              r_state   <= RUN;
              r_running <= 1'b1;
            end
          end

          DONE: begin
            r_count <= '0;
            if (AUTO_RELOAD != 0) begin
              if (r_reload != '0) begin
                r_count   <= r_reload;
                r_state   <= RUN;
                r_running <= 1'b1;
              end else begin
                r_done <= !r_done;
              end
            end else if (start && (r_reload != '0)) begin
              r_count   <= r_reload;
              r_state   <= RUN;
              r_running <= 1'b1;
            end
          end

          default: begin
            r_state   <= IDLE;
            r_running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count   = r_count;
  assign running = r_running;
  assign zero    = (r_count == '0);
  assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_countdown_ctrl.sv
// ----------------------------------------------------------------------------
// tb_countdown_ctrl : directed + random checks of countdown_ctrl against a model (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module tb_countdown_ctrl;

  localparam int P = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_value = 4'd0;

  logic [3:0] count0, count1;
  logic       running0, running1, zero0, zero1, done0, done1;

  always #5 clk = ~clk;

  countdown_ctrl #(
    .WIDTH(4), .PRESCALE(P), .START_VALUE(4'd15), .AUTO_RELOAD(0)
  ) dut0 (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .load(load),
    .load_value(load_value), .count(count0), .running(running0),
    .zero(zero0), .done(done0)
  );

  countdown_ctrl #(
    .WIDTH(4), .PRESCALE(P), .START_VALUE(4'd15), .AUTO_RELOAD(1)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .load(load),
    .load_value(load_value), .count(count1), .running(running1),
    .zero(zero1), .done(done1)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the count is derived from how many un-paused run cycles
  // have elapsed since the countdown began, divided by the prescale factor.
  // mode: 0 idle, 1 counting, 2 paused, 3 finished
  int m_mode[2];
  int m_base[2];
  int m_reload[2];
  int m_runcyc[2];
  bit m_done[2];

  function automatic int m_count(int k);
    if (m_mode[k] == 1 || m_mode[k] == 2) return m_base[k] - m_runcyc[k] / P;
    if (m_mode[k] == 3) return 0;
    return m_base[k];
  endfunction

  function automatic void model_step(int k, bit autor);
    bit prev_done;
    prev_done = m_done[k];
    m_done[k] = 1'b0;
    if (reset) begin
      m_mode[k] = 0; m_base[k] = 15; m_reload[k] = 15; m_runcyc[k] = 0;
    end else if (load) begin
      m_mode[k] = 0; m_base[k] = int'(load_value); m_reload[k] = int'(load_value);
      m_runcyc[k] = 0;
    end else if (m_mode[k] == 0) begin
      if (start) begin
        if (m_base[k] != 0) begin
          m_mode[k] = 1; m_runcyc[k] = 0;
        end else begin
          m_mode[k] = 3; m_done[k] = 1'b1;
        end
      end
    end else if (m_mode[k] == 1) begin
      if (pause) m_mode[k] = 2;
      else begin
        m_runcyc[k]++;
        if (m_count(k) <= 0) begin
          m_mode[k] = 3; m_done[k] = 1'b1;
        end
      end
    end else if (m_mode[k] == 2) begin
      if (!pause) m_mode[k] = 1;
    end else begin
      if (autor) begin
        if (m_reload[k] != 0) begin
          m_mode[k] = 1; m_base[k] = m_reload[k]; m_runcyc[k] = 0;
        end else begin
          m_done[k] = !prev_done;
        end
      end else if (start && m_reload[k] != 0) begin
        m_mode[k] = 1; m_base[k] = m_reload[k]; m_runcyc[k] = 0;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("m0.count",   32'(count0),   32'(m_count(0)));
    chk("m0.running", 32'(running0), 32'(m_mode[0] == 1));
    chk("m0.zero",    32'(zero0),    32'(m_count(0) == 0));
    chk("m0.done",    32'(done0),    32'(m_done[0]));
    chk("m1.count",   32'(count1),   32'(m_count(1)));
    chk("m1.running", 32'(running1), 32'(m_mode[1] == 1));
    chk("m1.zero",    32'(zero1),    32'(m_count(1) == 0));
    chk("m1.done",    32'(done1),    32'(m_done[1]));
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0, 1'b0);
    model_step(1, 1'b1);
    #1;
    check_model();
  endtask

  initial begin
    // 1: reset and idle hold
    reset = 1'b1;
    step(); step();
    chk("t1.reset_count", 32'(count0), 32'd15);
    chk("t1.reset_running", 32'(running0), 32'd0);
    chk("t1.reset_zero", 32'(zero0), 32'd0);
    chk("t1.reset_done", 32'(done0), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t1.idle_hold", 32'(count0), 32'd15);
    end

    // 2: full countdown from 15
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t2.running", 32'(running0), 32'd1);
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i == 2)  chk("t2.first_dec", 32'(count0), 32'd14);
      if (i == 29) chk("t2.no_early_done", 32'(done0), 32'd0);
    end
    chk("t2.end_count", 32'(count0), 32'd0);
    chk("t2.done_pulse", 32'(done0), 32'd1);
    step();
    chk("t2.done_cleared", 32'(done0), 32'd0);
    chk("t2.zero_held", 32'(zero0), 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t2.restart_count", 32'(count0), 32'd15);
    chk("t2.restart_running", 32'(running0), 32'd1);

    // 3: pause at count 9, resume on the saved prescaler phase
    for (int i = 0; i < 40 && m_count(0) != 9; i++) step();
    chk("t3.reach9", 32'(count0), 32'd9);
    step();
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3.paused_count", 32'(count0), 32'd9);
      chk("t3.paused_running", 32'(running0), 32'd0);
    end
    pause = 1'b0;
    step();
    chk("t3.resume_count", 32'(count0), 32'd9);
    chk("t3.resume_running", 32'(running0), 32'd1);
    step();
    chk("t3.resume_phase", 32'(count0), 32'd8);

    // 4: load mid-run, then load+start together
    load = 1'b1; load_value = 4'd3;
    step();
    load = 1'b0;
    chk("t4.load_count", 32'(count0), 32'd3);
    chk("t4.load_idle", 32'(running0), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 5) chk("t4.not_yet_done", 32'(done0), 32'd0);
    end
    chk("t4.done_at_6", 32'(done0), 32'd1);
    load = 1'b1; start = 1'b1; load_value = 4'd5;
    step();
    load = 1'b0; start = 1'b0;
    chk("t4.ls_count", 32'(count0), 32'd5);
    chk("t4.ls_running", 32'(running0), 32'd0);
    chk("t4.ls_count_auto", 32'(count1), 32'd5);

    // 5: reset mid-run, start from zero
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20 && m_count(0) != 7; i++) step();
    load = 1'b1; load_value = 4'd9;
    step();
    load = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20 && m_count(0) != 7; i++) step();
    chk("t5.at7", 32'(count0), 32'd7);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5.reset_count", 32'(count0), 32'd15);
    chk("t5.reset_running", 32'(running0), 32'd0);
    chk("t5.reset_done", 32'(done0), 32'd0);
    load = 1'b1; load_value = 4'd0;
    step();
    load = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t5.zero_start_done", 32'(done0), 32'd1);
    chk("t5.zero_start_zero", 32'(zero0), 32'd1);
    step();
    chk("t5.single_pulse", 32'(done0), 32'd0);
    step(); step();

    // 6: auto-reload with reload value 2
    reset = 1'b1;
    step();
    reset = 1'b0;
    load = 1'b1; load_value = 4'd2;
    step();
    load = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t6.start_count", 32'(count1), 32'd2);
    for (int i = 1; i <= 20; i++) begin
      step();
      chk($sformatf("t6.done_c%0d", i), 32'(done1), 32'((i % 5) == 4));
    end

    // random phase
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(0, 79) == 0);
      load       = ($urandom_range(0, 15) == 0);
      start      = ($urandom_range(0, 5) == 0);
      pause      = ($urandom_range(0, 4) == 0);
      load_value = 4'($urandom_range(0, 15));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
